// File: rtl/logic_unit_arbiter_if.sv
// logic_unit_arbiter_if: request/operand/result bundle between NREQ requesters
// and the shared logic-unit arbiter.
//   master: requester side (drives req/op/operands, observes ack/result)
//   slave : arbiter side
interface logic_unit_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op_in;
  logic [WIDTH*NREQ-1:0] a_in;
  logic [WIDTH*NREQ-1:0] b_in;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      result;
  logic [IDW-1:0]        grant_id;
  logic                  busy;

  modport master (
    output req, op_in, a_in, b_in,
    input  ack, result, grant_id, busy
  );

  modport slave (
    input  req, op_in, a_in, b_in,
    output ack, result, grant_id, busy
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: shares one registered AND/OR/XOR/NAND unit between NREQ
// requesters. IDLE picks a winner and captures its op/operands, GRANT computes,
// EXEC publishes the result and pulses ack for the winner (1 op per 3 cycles).
// Build option: define LOGIC_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no round-robin pointer); default is round-robin.
module logic_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  logic_unit_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_EXEC  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] calc_q, calc_d;      // computed in GRANT, published in EXEC
  logic [WIDTH-1:0] result_q, result_d;  // visible result, changes only on ack
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [NREQ-1:0]  ack_q, ack_d;

  logic             win_valid;
  logic [IDW-1:0]   win_idx;

  function automatic logic [WIDTH-1:0] logic_fn(input logic [1:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   logic_fn = a & b;
      2'b01:   logic_fn = a | b;
      2'b10:   logic_fn = a ^ b;
      default: logic_fn = ~(a & b);
    endcase
  endfunction

`ifdef LOGIC_ARB_FIXED_PRIO_EN
  // Winner select: lowest-index active request wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[k]) begin
        win_valid = 1'b1;
        win_idx   = IDW'(k);
      end
    end
  end
`else
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] scan_idx;

  // Winner select: scan upward from rr_ptr with wrap, first active request wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!win_valid && bus.req[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_valid) state_d = S_GRANT;
      S_GRANT: state_d = S_EXEC;
      S_EXEC:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: capture in IDLE, compute in GRANT, publish in EXEC.
  always_comb begin
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    calc_d     = calc_q;
    result_d   = result_q;
    grant_id_d = grant_id_q;
    ack_d      = '0;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          op_d       = bus.op_in[2*int'(win_idx) +: 2];
          a_d        = bus.a_in[WIDTH*int'(win_idx) +: WIDTH];
          b_d        = bus.b_in[WIDTH*int'(win_idx) +: WIDTH];
          grant_id_d = win_idx;
        end
      end
      S_GRANT: calc_d = logic_fn(op_q, a_q, b_q);
      S_EXEC: begin
        result_d             = calc_q;
        ack_d[grant_id_q]    = 1'b1;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
        rr_ptr_d = (int'(grant_id_q) == NREQ - 1) ? '0 : grant_id_q + 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: captured operands are reset as well, so no X can ever reach result.
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      calc_q     <= '0;
      result_q   <= '0;
      grant_id_q <= '0;
      ack_q      <= '0;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      calc_q     <= calc_d;
      result_q   <= result_d;
      grant_id_q <= grant_id_d;
      ack_q      <= ack_d;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  // Outputs: busy decoded from state, the rest straight from registers.
  always_comb begin
    bus.busy     = (state_q == S_GRANT) || (state_q == S_EXEC);
    bus.ack      = ack_q;
    bus.result   = result_q;
    bus.grant_id = grant_id_q;
  end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed scenarios with literal expectations plus a
// randomized requester phase, all checked every cycle against a transaction-
// level model (winner pick, 2-edge countdown to ack, result of the chosen op).
module tb_logic_unit_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) ifc ();

  logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int start);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (start + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  int               m_ptr    = 0;  // where the next search starts
  int               m_left   = 0;  // edges remaining until ack; 0 means idle
  int               m_gid    = 0;
  int               m_w      = 0;
  logic [WIDTH-1:0] m_exp    = '0;
  logic [WIDTH-1:0] m_result = '0;
  logic [NREQ-1:0]  m_ack    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; m_left = 0; m_gid = 0; m_exp = '0; m_result = '0; m_ack = '0;
    end else begin
      m_ack = '0;
      if (m_left == 0) begin
`ifdef LOGIC_ARB_FIXED_PRIO_EN
        m_w = pick(ifc.req, 0);
`else
        m_w = pick(ifc.req, m_ptr);
`endif
        if (m_w >= 0) begin
          m_gid  = m_w;
          m_exp  = ref_op(ifc.op_in[2*m_w +: 2], ifc.a_in[WIDTH*m_w +: WIDTH],
                          ifc.b_in[WIDTH*m_w +: WIDTH]);
          m_left = 2;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_ack[m_gid] = 1'b1;
          m_result     = m_exp;
          m_ptr        = (m_gid + 1) % NREQ;
        end
      end
    end
  end

  // Compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_ack",      ifc.ack,      m_ack);
      check("model_result",   ifc.result,   m_result);
      check("model_grant_id", ifc.grant_id, m_gid);
      check("model_busy",     ifc.busy,     m_left > 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    ifc.op_in[2*i +: 2]       = op;
    ifc.a_in[WIDTH*i +: WIDTH] = a;
    ifc.b_in[WIDTH*i +: WIDTH] = b;
    ifc.req[i]                = 1'b1;
  endtask

  task automatic wait_ack(output int cycles, output logic [NREQ-1:0] seen);
    cycles = 0;
    seen   = '0;
    while (cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (ifc.ack != '0) begin
        seen = ifc.ack;
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL ack_timeout actual=no ack expected=ack within 20 cycles at %0t", $time);
  endtask

  int              cyc;
  logic [NREQ-1:0] seen;
  logic [7:0]      exp3 [4];
  int              rr_exp [5];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp3   = '{8'h0A, 8'hAF, 8'hA5, 8'hF5};
    rr_exp = '{0, 1, 2, 3, 0};
    ifc.req   = '0;
    ifc.op_in = '0;
    ifc.a_in  = '0;
    ifc.b_in  = '0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Reset values.
    @(negedge clk);
    check("rst_ack",      ifc.ack,      4'b0000);
    check("rst_result",   ifc.result,   8'h00);
    check("rst_busy",     ifc.busy,     1'b0);
    check("rst_grant_id", ifc.grant_id, 2'd0);

    // Complete one op, then reset in the middle of the next one.
    set_req(1, 2'b10, 8'h5A, 8'hFF);
    wait_ack(cyc, seen);
    check("t1_ack",     seen,       4'b0010);
    check("t1_result",  ifc.result, 8'hA5);
    check("t1_latency", cyc,        3);
    ifc.req[1] = 1'b0;
    @(negedge clk);
    set_req(1, 2'b00, 8'hFF, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    check("t1_busy_exec", ifc.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_mid_rst_ack",      ifc.ack,      4'b0000);
    check("t1_mid_rst_result",   ifc.result,   8'h00);
    check("t1_mid_rst_busy",     ifc.busy,     1'b0);
    check("t1_mid_rst_grant_id", ifc.grant_id, 2'd0);
    ifc.req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_no_ack_after_rst", ifc.ack, 4'b0000);
    end

`ifndef LOGIC_ARB_FIXED_PRIO_EN
    // All requesters continuously requesting: grants rotate.
    for (int i = 0; i < NREQ; i++) set_req(i, 2'(i), 8'(8'h11 * (i + 1)), 8'hC3);
    for (int g = 0; g < 5; g++) begin
      wait_ack(cyc, seen);
      check("t4_grant_id", ifc.grant_id, rr_exp[g]);
      check("t4_ack",      seen,         4'b0001 << rr_exp[g]);
      if (g == 0) check("t4_first_latency", cyc,     3);
      else        check("t4_ack_spacing",   cyc + 1, 3);
      if (g == 4) begin
        ifc.req = '0;
      end else begin
        ifc.req[ifc.grant_id] = 1'b0;
        @(negedge clk);
        ifc.req = 4'b1111;
      end
    end
    @(negedge clk);
`endif

    // Single op on requester 2.
    set_req(2, 2'b00, 8'hF0, 8'h3C);
    wait_ack(cyc, seen);
    check("t2_ack",     seen,       4'b0100);
    check("t2_result",  ifc.result, 8'h30);
    check("t2_latency", cyc,        3);
    ifc.req[2] = 1'b0;
    @(negedge clk);

    // Requester 3, then 0 and 2 together: search restarts at 0.
    set_req(3, 2'b01, 8'h81, 8'h18);
    wait_ack(cyc, seen);
    check("t5_ack3",    seen,       4'b1000);
    check("t5_result3", ifc.result, 8'h99);
    ifc.req[3] = 1'b0;
    set_req(0, 2'b11, 8'hF0, 8'h0F);
    set_req(2, 2'b10, 8'h3C, 8'h0F);
    wait_ack(cyc, seen);
    check("t5_grant_wrap", ifc.grant_id, 2'd0);
    check("t5_ack0",       seen,         4'b0001);
    check("t5_result0",    ifc.result,   8'hFF);
    ifc.req[0] = 1'b0;
    wait_ack(cyc, seen);
    check("t5_grant_next", ifc.grant_id, 2'd2);
    check("t5_result2",    ifc.result,   8'h33);
    ifc.req[2] = 1'b0;
    @(negedge clk);

    // All four ops on requester 0.
    for (int op = 0; op < 4; op++) begin
      set_req(0, 2'(op), 8'hAA, 8'h0F);
      wait_ack(cyc, seen);
      check("t3_ack",    seen,       4'b0001);
      check("t3_result", ifc.result, exp3[op]);
      ifc.req[0] = 1'b0;
      @(negedge clk);
    end

`ifdef LOGIC_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 1 always beats requester 3.
    set_req(1, 2'b01, 8'h0F, 8'hF0);
    set_req(3, 2'b00, 8'hFF, 8'hFF);
    for (int g = 0; g < 4; g++) begin
      wait_ack(cyc, seen);
      check("t6_grant_id", ifc.grant_id, 2'd1);
      check("t6_ack",      seen,         4'b0010);
    end
    ifc.req = '0;
    @(negedge clk);
`endif

    // Randomized requesters; operands churn freely, capture point is what matters.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(1, 0) == 1) begin
          ifc.op_in[2*i +: 2]       = 2'($urandom);
          ifc.a_in[WIDTH*i +: WIDTH] = 8'($urandom);
          ifc.b_in[WIDTH*i +: WIDTH] = 8'($urandom);
        end
        if (ifc.ack[i])                          ifc.req[i] = 1'b0;
        else if (ifc.req[i]) begin
          if ($urandom_range(15, 0) == 0)        ifc.req[i] = 1'b0;
        end else if ($urandom_range(2, 0) == 0)  ifc.req[i] = 1'b1;
      end
    end
    ifc.req = '0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
